// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings and helpers for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        RD_WORD   = 3'd0,
        RD_HALF_S = 3'd1,
        RD_HALF_U = 3'd2,
        RD_BYTE_S = 3'd3,
        RD_BYTE_U = 3'd4
    } read_part_e;

    typedef enum logic [1:0] {
        WR_WORD = 2'd0,
        WR_HALF = 2'd1,
        WR_BYTE = 2'd2
    } write_part_e;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_GNT_IF        = 2'd1,
        ST_GNT_DM        = 2'd2,
        ST_GNT_IF_FORCED = 2'd3
    } arb_state_e;

    // Access size classes used for the alignment check.
    localparam logic [1:0] MEM_WORD = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_BYTE = 2'd2;

    // Unused read encodings behave as byte accesses (never misaligned).
    function automatic logic [1:0] rd_size(input logic [2:0] part);
        case (part)
            RD_WORD:              return MEM_WORD;
            RD_HALF_S, RD_HALF_U: return MEM_HALF;
            default:              return MEM_BYTE;
        endcase
    endfunction

    function automatic logic [1:0] wr_size(input logic [1:0] part);
        case (part)
            WR_WORD: return MEM_WORD;
            WR_HALF: return MEM_HALF;
            default: return MEM_BYTE;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            MEM_WORD: return addr_lo != 2'b00;
            MEM_HALF: return addr_lo[0];
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// rtl/mem_port_arbiter_sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count up on inc, hold at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for a single-ported unified memory
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_instr,
    output logic              if_stall,
    input  logic              dm_read,
    input  logic              dm_write,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [2:0]        dm_read_part,
    input  logic [1:0]        dm_write_part,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_stall,
    output logic              dm_misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_read_part,
    output logic [1:0]        mem_write_part,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic [CNT_W-1:0]  fetch_stall_cnt,
    output logic [CNT_W-1:0]  data_stall_cnt
);

    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          dm_access, mis, dm_req, forced, gnt_if, gnt_dm;

    // Request qualification and grant decision; reset suppresses every grant.
    always_comb begin
        dm_access = dm_read | dm_write;
        mis       = !rst && dm_access &&
                    is_misaligned(dm_write ? wr_size(dm_write_part) : rd_size(dm_read_part),
                                  dm_addr[1:0]);
        dm_req    = !rst && dm_access && !mis;
        forced    = !rst && if_req && dm_req && (starve_cnt_q == STARVE_MAX);
        gnt_if    = !rst && if_req && (!dm_req || forced);
        gnt_dm    = dm_req && !gnt_if;
    end

    // Consecutive-denied-fetch counter; any gap in fetch requests forgets history.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (rst || !if_req || gnt_if) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    // Next state records which requester won this cycle.
    always_comb begin
        state_d = ST_IDLE;
        if (forced) begin
            state_d = ST_GNT_IF_FORCED;
        end else if (gnt_if) begin
            state_d = ST_GNT_IF;
        end else if (gnt_dm) begin
            state_d = ST_GNT_DM;
        end
    end

    // State and starvation registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Memory port and pipeline outputs driven from the current grant.
    always_comb begin
        mem_addr       = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_read_part  = '0;
        mem_write_part = '0;
        mem_wdata      = '0;
        if_instr       = '0;
        dm_rdata       = '0;
        if (gnt_if) begin
            mem_addr      = if_addr;
            mem_read      = 1'b1;
            mem_read_part = RD_WORD;
            if_instr      = mem_rdata;
        end else if (gnt_dm) begin
            mem_addr = dm_addr;
            if (dm_write) begin
                mem_write      = 1'b1;
                mem_write_part = dm_write_part;
                mem_wdata      = dm_wdata;
            end else begin
                mem_read      = 1'b1;
                mem_read_part = dm_read_part;
                dm_rdata      = mem_rdata;
            end
        end
        if_stall      = !rst && if_req && !gnt_if;
        dm_stall      = dm_req && !gnt_dm;
        dm_misaligned = mis;
    end

    // A forced fetch always wipes the starvation history it was granted on.
    a_forced_clears: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_GNT_IF_FORCED) |-> (starve_cnt_q == '0));

    sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clk (clk),
        .clr (rst),
        .inc (if_stall),
        .cnt (fetch_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_data_cnt (
        .clk (clk),
        .clr (rst),
        .inc (dm_stall),
        .cnt (data_stall_cnt)
    );

endmodule
